nshift: RTL and testbench
=========================

Name: nshift

Overview:
- Parameterised N-bit serial-in, parallel-out bidirectional shift register.
- One serial data bit `d` enters at the LSB or the MSB, depending on direction.
- The full register contents are presented on `out` every cycle.
- Used as a generic serial-to-parallel / direction-selectable shifting element in datapaths and small test structures.

Parameters:
- N, 4, register width in bits. Legal range N >= 1.

Ports:
- clk  input  1  rising-edge clock; all state changes on posedge clk only.
- rst  input  1  synchronous reset, active-high; clears the register.
- en  input  1  shift enable, active-high; register holds when low.
- dir  input  1  shift direction: 0 = shift toward MSB (left), 1 = shift toward LSB (right).
- d  input  1  serial data bit inserted at the vacated end on each enabled shift.
- out  output  N  current register contents; out[N-1] is MSB, out[0] is LSB.

Behaviour:
- State: one N-bit register `q`. `out` is driven directly from `q`, with no combinational path from any input to `out`.
- Evaluation at each rising edge of clk, in priority order:
  - rst = 1: q <= {N{1'b0}}. Reset wins over en, dir and d.
  - rst = 0, en = 0: q <= q (hold).
  - rst = 0, en = 1, dir = 0: q <= {q[N-2:0], d}. Left shift, d enters the LSB, old MSB is discarded.
  - rst = 0, en = 1, dir = 1: q <= {d, q[N-1:1]}. Right shift, d enters the MSB, old LSB is discarded.
- N = 1: both directions reduce to q <= d when enabled.
- Reset value of out: all zeros, visible from the first edge at which rst is sampled high.
- Before the first reset, q is undefined (X in simulation). No power-on value is guaranteed.
- Latency: a value on d appears at out[0] (dir = 0) or out[N-1] (dir = 1) one clock after the enabled edge.
  - Reaching the opposite end takes N enabled edges in the same direction.
- Direction change: dir may change on any cycle. Each edge uses the dir sampled at that edge, and no internal state is cleared on a change.
- Enable gaps: disabled cycles do not disturb alignment. Shifting resumes from the held value.
- Mid-operation reset: asserting rst for one edge clears q regardless of shift in progress. Shifting resumes on the next edge with rst = 0 and en = 1.
- en, dir and d are sampled only at rising edges. Glitches between edges have no effect.
- No handshake, no overflow/underflow flags: bits shifted out are lost.

Test Plan:
- Reset: drive q to 4'b1011, then rst = 1 for one edge with en = 1, d = 1 -> out = 4'b0000 after that edge. Reset overrides enable.
- Left fill: N = 4, from 0000, en = 1, dir = 0, d = 1 for 4 edges -> out = 0001, 0011, 0111, 1111. A 5th edge with d = 0 -> 1110.
- Right fill: from 0000, en = 1, dir = 1, d = 1 for 4 edges -> out = 1000, 1100, 1110, 1111. A 5th edge with d = 0 -> 0111.
- Hold: load 1010, then en = 0 for 10 edges with d and dir toggling -> out stays 1010 throughout.
- Direction switch: from 0000, dir = 0, d = 1 for 2 edges -> 0011. Then dir = 1, d = 0 for 1 edge -> 0001. Then dir = 0, d = 0 for 1 edge -> 0010.
- Parameter sweep: repeat the fill tests with N = 1 (out follows d one edge later in both directions) and N = 8 (full fill after exactly 8 enabled edges). Compare against a reference model every cycle.

Source files
------------

// File: rtl/nshift.sv
// N-bit serial-in, parallel-out shift register with selectable shift direction.
// The serial bit enters the vacated end; the bit pushed out of the other end is discarded.
module nshift #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         dir,
   input  logic         d,
   output logic [N-1:0] out
);

   logic [N-1:0] r_q;
   logic [N-1:0] w_shl;
   logic [N-1:0] w_shr;

   // A single-bit register has no neighbours, so both directions just load d.
   generate
      if (N == 1) begin : g_one
         assign w_shl = d;
         assign w_shr = d;
      end else begin : g_multi
         assign w_shl = {r_q[N-2:0], d};
         assign w_shr = {d, r_q[N-1:1]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= '0;
      end else if (en) begin
         r_q <= dir ? w_shr : w_shl;
      end
   end

   assign out = r_q;

endmodule

// File: tb/tb_nshift.sv
// Randomized and directed bench for nshift at widths 1, 4 and 8, checked against
// an arithmetic reference model every cycle.
module tb_nshift;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en  = 1'b0;
   logic       dir = 1'b0;
   logic       d   = 1'b0;
   logic [0:0] out1;
   logic [3:0] out4;
   logic [7:0] out8;

   int vectors = 0;
   int errs    = 0;
   int m1 = 0, m4 = 0, m8 = 0;

   always #5 clk = ~clk;

   nshift #(.N(1)) u_n1 (.clk(clk), .rst(rst), .en(en), .dir(dir), .d(d), .out(out1));
   nshift #(.N(4)) u_n4 (.clk(clk), .rst(rst), .en(en), .dir(dir), .d(d), .out(out4));
   nshift #(.N(8)) u_n8 (.clk(clk), .rst(rst), .en(en), .dir(dir), .d(d), .out(out8));

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %b, expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   // Register value as a number: left shift doubles and adds d, right shift halves
   // and adds d weighted by the MSB position.
   function automatic int mdl(input int v, input int n, input bit r, input bit e,
                              input bit dr, input bit dd);
      int mask;
      mask = (1 << n) - 1;
      if (r)  return 0;
      if (!e) return v;
      if (!dr) return ((v * 2) + int'(dd)) & mask;
      return (v / 2) + (int'(dd) << (n - 1));
   endfunction

   task automatic step(input bit r, input bit e, input bit dr, input bit dd);
      rst = r; en = e; dir = dr; d = dd;
      @(posedge clk);
      m1 = mdl(m1, 1, r, e, dr, dd);
      m4 = mdl(m4, 4, r, e, dr, dd);
      m8 = mdl(m8, 8, r, e, dr, dd);
      #1;
      chk("model_n1", {7'b0, out1}, m1[7:0]);
      chk("model_n4", {4'b0, out4}, m4[7:0]);
      chk("model_n8", out8, m8[7:0]);
   endtask

   initial begin
      logic [3:0] lfill [4];
      logic [3:0] rfill [4];
      logic [3:0] load;
      lfill = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
      rfill = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};

      @(posedge clk); #1;
      step(1, 0, 0, 0);
      chk("reset_n4", {4'b0, out4}, 8'h00);
      chk("reset_n8", out8, 8'h00);

      // Load 1011, then reset with enable and d high.
      load = 4'b1011;
      for (int i = 3; i >= 0; i--) step(0, 1, 0, load[i]);
      chk("load_1011", {4'b0, out4}, 8'h0B);
      step(1, 1, 0, 1);
      chk("reset_over_en", {4'b0, out4}, 8'h00);

      // Left fill, then a zero.
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 0, 1);
         chk("lfill_n4", {4'b0, out4}, {4'b0, lfill[i]});
      end
      step(0, 1, 0, 0);
      chk("lfill_tail", {4'b0, out4}, 8'h0E);

      // Right fill, then a zero.
      step(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 1, 1);
         chk("rfill_n4", {4'b0, out4}, {4'b0, rfill[i]});
      end
      step(0, 1, 1, 0);
      chk("rfill_tail", {4'b0, out4}, 8'h07);

      // Hold 1010 across ten disabled edges.
      step(1, 0, 0, 0);
      load = 4'b1010;
      for (int i = 3; i >= 0; i--) step(0, 1, 0, load[i]);
      for (int i = 0; i < 10; i++) begin
         step(0, 0, i[0], ~i[1]);
         chk("hold_n4", {4'b0, out4}, 8'h0A);
      end

      // Direction switch.
      step(1, 0, 0, 0);
      step(0, 1, 0, 1);
      step(0, 1, 0, 1);
      chk("dsw_left", {4'b0, out4}, 8'h03);
      step(0, 1, 1, 0);
      chk("dsw_right", {4'b0, out4}, 8'h01);
      step(0, 1, 0, 0);
      chk("dsw_back", {4'b0, out4}, 8'h02);

      // N=8 full fill takes exactly eight edges; N=1 follows d.
      step(1, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         step(0, 1, 0, 1);
         if (i == 6) chk("n8_not_full", out8, 8'h7F);
      end
      chk("n8_full", out8, 8'hFF);
      for (int i = 0; i < 8; i++) begin
         step(0, 1, i[1], i[0]);
         chk("n1_follow", {7'b0, out1}, {7'b0, i[0]});
      end

      // Random traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
              1'($urandom), 1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
